// File: rtl/rr_arb_pkg.sv
// Shared definitions for the eight-requester round-robin arbiter.
//   NREQ / IDX_W : requester count and matching binary index width
//   state_t      : two-state arbitration FSM encoding
//   rr_pick      : rotate-priority search returning {found, winner_index}
package rr_arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Scan ptr, ptr+1, ... (mod NREQ) and return the first requester found.
    // The loop runs from the farthest slot back towards ptr so that the last
    // assignment made is the nearest requester, which is the one that wins.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NREQ-1:0]  req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W:0]   res;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/grant_onehot_dec.sv
// Combinational 3-to-8 decode of the winner index into a one-hot grant vector.
//   en     : in  1      decode enable; all outputs zero when low
//   idx    : in  IDX_W  binary index
//   onehot : out NREQ   one-hot result, bit idx set when en is high
module grant_onehot_dec
    import rr_arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Eight-requester round-robin arbiter with hold-until-done tenure.
//   clk       : in  1  rising-edge clock
//   rst_n     : in  1  asynchronous active-low reset
//   req       : in  8  level request per client
//   done      : in  1  current owner finished (looked at only while granted)
//   gnt       : out 8  registered one-hot grant, zero when idle
//   gnt_idx   : out 3  registered binary owner index, zero when idle
//   gnt_valid : out 1  a grant is active
//   timeout   : out 1  one-cycle pulse when a grant is revoked by the tenure limit
// Optional feature: define RR_ARB_TIMEOUT_EN to limit tenure to HOLD_MAX
// cycles; without it HOLD_MAX has no effect and timeout is held at 0.
module rr_grant_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic             timeout_reg, timeout_next;
    logic [IDX_W:0]   pick;
    logic             tmo_hit;
    logic             rel;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign tmo_hit = (state_reg == ST_GRANT) && (cnt_reg == CNT_W'(HOLD_MAX));

    // Tenure counts 1 on the first granted cycle, so a grant lasts exactly
    // HOLD_MAX cycles before the limit releases it.
    always_comb begin
        cnt_next = '0;
        if (state_next == ST_GRANT) begin
            cnt_next = (state_reg == ST_GRANT) ? cnt_reg + 1'b1 : CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    // HOLD_MAX only matters with the tenure limit compiled in.
    logic [31:0] unused_hold_max;
    assign unused_hold_max = 32'(HOLD_MAX);
    assign tmo_hit         = 1'b0;
`endif

    assign pick = rr_pick(req, ptr_reg);
    assign rel  = done || !req[gnt_idx_reg] || tmo_hit;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_idx_next = gnt_idx_reg;
        timeout_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick[IDX_W]) begin
                    state_next   = ST_GRANT;
                    gnt_idx_next = pick[IDX_W-1:0];
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    state_next   = ST_IDLE;
                    gnt_idx_next = '0;
                    // Natural 3-bit wrap takes owner 7 back to slot 0.
                    ptr_next     = gnt_idx_reg + 1'b1;
                    // done on the limit cycle counts as an ordinary release.
                    timeout_next = tmo_hit && !done;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    grant_onehot_dec u_dec (
        .en     (state_next == ST_GRANT),
        .idx    (gnt_idx_next),
        .onehot (gnt_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
            gnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_idx_reg <= gnt_idx_next;
            gnt_reg     <= gnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = (state_reg == ST_GRANT);
    assign timeout   = timeout_reg;

endmodule
